// File: rtl/scan_capture.sv
// Receive side of the six-digit multiplexed scan bus: rebuilds live digits,
// a frame-coherent shadow copy, and tracks scan order / sync with sticky errors.
module scan_capture #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        QA,
    input  logic        QB,
    input  logic        QC,
    input  logic        QD,
    input  logic        QE,
    input  logic        QF,
    input  logic [3:0]  D,
    output logic [23:0] DOUT,
    output logic [23:0] FRAME_Q,
    output logic        FRAME,
    output logic        SYNC,
    output logic        ERR,
    output logic [1:0]  ERR_CODE
);

    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] LOCK  = 2'd2;

    localparam logic [1:0] E_MULTI = 2'b01;
    localparam logic [1:0] E_ORDER = 2'b10;
    localparam logic [1:0] E_TOUT  = 2'b11;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [2:0]  run_q, run_d, run_inc;
    logic [2:0]  exp_q, exp_d, exp_k;
    logic [7:0]  idle_q, idle_d;
    logic [23:0] dout_q, dout_d, fq_q, fq_d;
    logic        frame_q, frame_d, err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic [5:0]  strb;
    logic        is_idle, is_valid, is_ill;
    logic [2:0]  k;
    logic        flag;
    logic [1:0]  flag_code;

    // Strobes are active low; strb[i] high means digit i is being driven.
    always_comb begin
        strb     = ~{QF, QE, QD, QC, QB, QA};
        is_idle  = (strb == 6'd0);
        is_valid = $onehot(strb);
        is_ill   = !is_idle && !is_valid;
        k        = 3'd0;
        for (int i = 0; i < 6; i++)
            if (strb[i]) k = 3'(i);
        exp_k    = (k == 3'd0) ? 3'd5 : k - 3'd1;
        run_inc  = (run_q == 3'd6) ? 3'd6 : run_q + 3'd1;
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        exp_d     = exp_q;
        idle_d    = idle_q;
        dout_d    = dout_q;
        fq_d      = fq_q;
        frame_d   = 1'b0;
        flag      = 1'b0;
        flag_code = 2'b00;

        if (is_valid) begin
            dout_d[{k, 2'b00} +: 4] = D;
            idle_d = 8'd0;
            exp_d  = exp_k;
        end

        if (state_q == HUNT) begin
            if (is_valid) begin
                state_d = TRACK;
                run_d   = 3'd1;
            end else if (is_ill) begin
                flag      = 1'b1;
                flag_code = E_MULTI;
            end
        end else begin
            if (is_valid) begin
                if (k == exp_q) begin
                    run_d = run_inc;
                    // Frame closes on digit A once six in-order digits are seen.
                    if (k == 3'd0 && run_inc == 3'd6) begin
                        frame_d = 1'b1;
                        fq_d    = dout_d;
                        state_d = LOCK;
                    end
                end else begin
                    flag      = 1'b1;
                    flag_code = E_ORDER;
                    state_d   = TRACK;
                    run_d     = 3'd1;
                end
            end else if (is_ill) begin
                flag      = 1'b1;
                flag_code = E_MULTI;
                state_d   = HUNT;
                run_d     = 3'd0;
            end else begin
                idle_d = idle_q + 8'd1;
                if (idle_d >= TO) begin
                    idle_d    = TO;
                    flag      = 1'b1;
                    flag_code = E_TOUT;
                    state_d   = HUNT;
                    run_d     = 3'd0;
                end
            end
        end

        err_d  = err_q;
        code_d = code_q;
        if (flag && !err_q) begin
            err_d  = 1'b1;
            code_d = flag_code;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= HUNT;
            run_q   <= 3'd0;
            exp_q   <= 3'd5;
            idle_q  <= 8'd0;
            dout_q  <= 24'd0;
            fq_q    <= 24'd0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            exp_q   <= exp_d;
            idle_q  <= idle_d;
            dout_q  <= dout_d;
            fq_q    <= fq_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign DOUT     = dout_q;
    assign FRAME_Q  = fq_q;
    assign FRAME    = frame_q;
    assign SYNC     = (state_q == LOCK);
    assign ERR      = err_q;
    assign ERR_CODE = code_q;

endmodule

// File: tb/tb_scan_capture.sv
// Directed and randomized checks of scan_capture against a digit-level
// behavioural model of the scan receiver.
module tb_scan_capture;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        QA = 1'b1, QB = 1'b1, QC = 1'b1, QD = 1'b1, QE = 1'b1, QF = 1'b1;
    logic [3:0]  D = 4'd0;
    logic [23:0] DOUT, FRAME_Q;
    logic        FRAME, SYNC, ERR;
    logic [1:0]  ERR_CODE;

    scan_capture #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .QA(QA), .QB(QB), .QC(QC), .QD(QD), .QE(QE), .QF(QF),
        .D(D), .DOUT(DOUT), .FRAME_Q(FRAME_Q), .FRAME(FRAME),
        .SYNC(SYNC), .ERR(ERR), .ERR_CODE(ERR_CODE)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 = searching, 1 = following order, 2 = locked.
    int m_dig[6];
    int m_fq[6];
    int m_mode, m_run, m_next, m_idle, m_err, m_code, m_frame;

    function automatic logic [23:0] pack_dig(input int v[6]);
        logic [23:0] r = 24'd0;
        for (int i = 0; i < 6; i++) r = r | (24'(v[i] & 15) << (4 * i));
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 6; i++) begin m_dig[i] = 0; m_fq[i] = 0; end
        m_mode = 0; m_run = 0; m_next = 5; m_idle = 0; m_err = 0; m_code = 0; m_frame = 0;
    endtask

    task automatic m_flag(input int c);
        if (m_err == 0) begin m_err = 1; m_code = c; end
    endtask

    task automatic m_step(input logic [5:0] low, input int d);
        int n = $countones(low);
        int k = 0;
        m_frame = 0;
        for (int i = 0; i < 6; i++) if (low[i]) k = i;
        if (n == 1) begin
            m_dig[k] = d;
            m_idle = 0;
            if (m_mode == 0) begin
                m_mode = 1; m_run = 1;
            end else if (k == m_next) begin
                m_run = (m_run + 1 > 6) ? 6 : m_run + 1;
                if (k == 0 && m_run == 6) begin
                    m_frame = 1; m_mode = 2;
                    for (int i = 0; i < 6; i++) m_fq[i] = m_dig[i];
                end
            end else begin
                m_flag(2); m_mode = 1; m_run = 1;
            end
            m_next = (k + 5) % 6;
        end else if (n > 1) begin
            m_flag(1);
            if (m_mode != 0) begin m_mode = 0; m_run = 0; end
        end else if (m_mode != 0) begin
            m_idle++;
            if (m_idle >= TO) begin m_idle = TO; m_flag(3); m_mode = 0; m_run = 0; end
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".DOUT"}, DOUT, pack_dig(m_dig));
        chk({tag, ".FRAME_Q"}, FRAME_Q, pack_dig(m_fq));
        chk({tag, ".FRAME"}, 24'(FRAME), 24'(m_frame));
        chk({tag, ".SYNC"}, 24'(SYNC), 24'(m_mode == 2));
        chk({tag, ".ERR"}, 24'(ERR), 24'(m_err));
        chk({tag, ".ERR_CODE"}, 24'(ERR_CODE), 24'(m_code));
    endtask

    // Drive one sample, clock it in, advance the model, check 1 time unit later.
    task automatic drive(input string tag, input logic [5:0] low, input int d);
        {QF, QE, QD, QC, QB, QA} = ~low;
        D = 4'(d);
        @(posedge CLK);
        m_step(low, d);
        #1;
        chk_all(tag);
    endtask

    task automatic digit(input string tag, input int k, input int d);
        drive(tag, 6'(1 << k), d);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) drive(tag, 6'd0, 0);
    endtask

    task automatic scan(input string tag, input int gap);
        for (int k = 5; k >= 0; k--) begin
            digit(tag, k, k);
            if (gap > 0 && k > 0) idle(tag, gap);
        end
    endtask

    task automatic do_reset();
        {QF, QE, QD, QC, QB, QA} = 6'h3f;
        #2 RSTN = 1'b0;
        m_reset();
        #1 chk_all("reset");
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    initial begin
        m_reset();
        #1 chk_all("por");
        @(negedge CLK);
        RSTN = 1'b1;

        // Clean scan twice; frames land 6 cycles apart with 24'h543210.
        scan("clean1", 0);
        chk("clean1.val", FRAME_Q, 24'h543210);
        scan("clean2", 0);
        chk("clean2.val", DOUT, 24'h543210);

        // Idle gaps below the timeout keep order and lock.
        do_reset();
        scan("gap1", 3);
        scan("gap2", 3);

        // Out-of-order after lock: F,E,C then re-anchored run.
        digit("ooo.F", 5, 9);
        digit("ooo.E", 4, 9);
        digit("ooo.C", 2, 7);
        chk("ooo.code", 24'(ERR_CODE), 24'd2);
        chk("ooo.fq", FRAME_Q, 24'h543210);
        digit("ooo.B", 1, 1);
        digit("ooo.A1", 0, 0);
        chk("ooo.noframe", 24'(FRAME), 24'd0);
        scan("ooo.run", 0);
        chk("ooo.frame2", 24'(FRAME), 24'd1);

        // Multi-strobe on fresh reset, later order error keeps code 01.
        do_reset();
        drive("multi.hunt", 6'b000101, 15);
        chk("multi.code", 24'(ERR_CODE), 24'd1);
        scan("multi.lock", 0);
        drive("multi.lock_ill", 6'b000101, 15);
        digit("multi.ooo", 3, 6);
        digit("multi.ooo2", 1, 6);

        // Timeout: 15 idles keep lock, 16 break it.
        do_reset();
        scan("to.lock", 0);
        idle("to.15", TO - 1);
        digit("to.keep", 5, 3);
        idle("to.16", TO);
        chk("to.code", 24'(ERR_CODE), 24'd3);
        idle("to.hunt", 3);

        // Asynchronous reset during digit C, then a full run is needed.
        do_reset();
        scan("mid.lock", 0);
        digit("mid.F", 5, 8);
        digit("mid.E", 4, 8);
        digit("mid.D", 3, 8);
        {QF, QE, QD, QC, QB, QA} = ~6'b000100;
        D = 4'd8;
        #2 RSTN = 1'b0;
        m_reset();
        #1 chk_all("mid.async");
        @(posedge CLK);
        #1 chk_all("mid.held");
        @(negedge CLK);
        RSTN = 1'b1;
        digit("mid.C", 2, 4);
        digit("mid.B", 1, 4);
        digit("mid.A", 0, 4);
        scan("mid.full", 0);

        // Randomized traffic, mostly in order with idles and faults.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 72) digit("rnd.ord", m_next, int'($urandom_range(0, 15)));
            else if (r < 86) drive("rnd.idle", 6'd0, 0);
            else if (r < 92) digit("rnd.any", int'($urandom_range(0, 5)), int'($urandom_range(0, 15)));
            else if (r < 95) drive("rnd.ill", 6'(1 << $urandom_range(0, 2)) | 6'(8 << $urandom_range(0, 2)), 3);
            else if (r < 97) idle("rnd.long", int'($urandom_range(10, 20)));
            else if (r < 98) do_reset();
            else drive("rnd.mask", 6'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
